// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte-stream requesters.
// Define UART_ARB_LOCK_EN to keep a requester's packet (up to req_last) unbroken on the line.
module uart_tx_arbiter #(
   parameter int unsigned NREQ           = 4,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   output logic [7:0]        uart_tx_data,
   output logic              uart_tx_start,
   input  logic              uart_tx_done,
   output logic [NREQ-1:0]   grant,
   output logic              busy,
   output logic              timeout_err
);

   localparam int unsigned PtrW = $clog2(NREQ);
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   // Watchdog fires in the WAIT cycle whose counter value is TIMEOUT_CYCLES-1.
   localparam logic [CntW-1:0] CntLimit = (TIMEOUT_CYCLES == 0) ? '0 : CntW'(TIMEOUT_CYCLES - 1);
   localparam logic [PtrW-1:0] LastIdx  = PtrW'(NREQ - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e            state_q, state_d;
   logic [PtrW-1:0]   ptr_q, ptr_d;
   logic [PtrW-1:0]   owner_q, owner_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [7:0]        data_q, data_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              terr_q, terr_d;
   logic [PtrW-1:0]   win, cand, next_ptr;
   logic              win_found;
   logic              finish;
   logic [NREQ-1:0]   ready_c;
   logic [7:0]        req_bytes [NREQ];

`ifdef UART_ARB_LOCK_EN
   logic lock_q, lock_d;
   logic last_q, last_d;
`else
   logic unused_last;
   assign unused_last = ^req_last;
`endif

   for (genvar g = 0; g < NREQ; g++) begin : g_bytes
      assign req_bytes[g] = req_data[8*g +: 8];
   end

   // Round-robin search starting at ptr_q, wrapping modulo NREQ.
   always_comb begin
      win       = '0;
      win_found = 1'b0;
      cand      = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = PtrW'((32'(ptr_q) + i) % NREQ);
         if (!win_found && req_valid[cand]) begin
            win       = cand;
            win_found = 1'b1;
         end
      end
`ifdef UART_ARB_LOCK_EN
      if (lock_q) begin
         win       = owner_q;
         win_found = req_valid[owner_q];
      end
`endif
      ready_c = '0;
      if (state_q == StIdle && win_found) begin
         ready_c[win] = 1'b1;
      end
   end

   assign next_ptr = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      grant_d = grant_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      terr_d  = terr_q;
      finish  = 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_d  = lock_q;
      last_d  = last_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               owner_d      = win;
               grant_d      = '0;
               grant_d[win] = 1'b1;
               data_d       = req_bytes[win];
               state_d      = StIssue;
`ifdef UART_ARB_LOCK_EN
               last_d       = req_last[win];
`endif
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            cnt_d = cnt_q + 1'b1;
            if (uart_tx_done) begin
               finish = 1'b1;
            end else if (TIMEOUT_CYCLES != 0 && cnt_q == CntLimit) begin
               finish = 1'b1;
               terr_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (finish) begin
         state_d = StIdle;
         cnt_d   = '0;
         ptr_d   = next_ptr;
         grant_d = '0;
`ifdef UART_ARB_LOCK_EN
         lock_d  = 1'b0;
         // A completed non-final byte keeps ownership; a timeout always releases it.
         if (uart_tx_done && !last_q) begin
            lock_d  = 1'b1;
            ptr_d   = ptr_q;
            grant_d = grant_q;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         owner_q <= '0;
         grant_q <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         terr_q  <= 1'b0;
`ifdef UART_ARB_LOCK_EN
         lock_q  <= 1'b0;
         last_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
`ifdef UART_ARB_LOCK_EN
         lock_q  <= lock_d;
         last_q  <= last_d;
`endif
      end
   end

   assign req_ready     = reset ? ready_c : '0;
   assign uart_tx_data  = data_q;
   assign uart_tx_start = (state_q == StIssue);
   assign grant         = grant_q;
   assign busy          = (state_q != StIdle);
   assign timeout_err   = terr_q;

endmodule
